dcache_refill_engine: RTL
=========================

Name: dcache_refill_engine

Overview:
- Memory-side responder for the data cache miss-repair interface.
- Accepts a held miss request (`read_miss_repair` + `missed_addr`), optionally writes back a dirty victim line, then fetches the 128-bit line over a 32-bit memory bus.
- Returns the assembled line with a one-cycle `repair_resolved` pulse.
- Sits between the dcache controller and the main-memory port.

Parameters:
- LINE_BITS, 128, cache line width in bits.
- BUS_BITS, 32, memory data bus width; BEATS = LINE_BITS/BUS_BITS (4).
- ADDR_BITS, 32, byte address width.

Ports:
- clk  in  1  single clock; one clock domain.
- rst  in  1  reset, asynchronous and active-low.
- read_miss_repair  in  1  miss request; level, held high by the controller until it sees `repair_resolved`.
- missed_addr  in  32  byte address of the missing word; sampled on acceptance.
- evict_dirty  in  1  victim line is dirty and needs write-back; sampled with the request.
- evict_addr  in  32  victim line address; sampled with the request.
- evict_data  in  128  victim line data; sampled with the request.
- repair_resolved  out  1  one-cycle pulse; the fill outputs are valid in this cycle.
- fill_data  out  128  refilled line, word 0 in bits [31:0].
- fill_addr  out  32  line-aligned address of the refilled line.
- busy  out  1  high from acceptance through the HOLD state.
- mem_req_valid  out  1  memory beat request.
- mem_req_ready  in  1  memory accepts the request; handshake = valid & ready.
- mem_req_we  out  1  1 = write beat, 0 = read beat.
- mem_req_addr  out  32  word-aligned beat address.
- mem_wdata  out  32  write beat data.
- mem_resp_valid  in  1  read data return.
- mem_rdata  in  32  read beat data.

Behaviour:
- Reset (async, rst=0): state IDLE, all outputs 0, beat counter 0, line buffer 0. Reset mid-transfer abandons the transfer immediately. Any in-flight memory response after reset release is ignored while in IDLE.
- Line base = address with bits [3:0] cleared. Beat k address = base + 4*k.
- IDLE: `read_miss_repair` = 1 captures `missed_addr`, `evict_*`, sets `busy` next cycle. Next state: WB if `evict_dirty`, else RD_REQ.
- WB: drive `mem_req_valid` = 1, `we` = 1, addr = evict base + 4*k, `wdata` = evict_data[32k+31:32k].
  - k advances on each handshake, k = 0..3 ascending.
  - After beat 3 handshake: RD_REQ with k = 0.
  - `valid`, `addr` and `wdata` stay stable while `ready` is low.
- RD_REQ: `mem_req_valid` = 1, `we` = 0, addr of beat k. On handshake: RD_WAIT; `valid` drops that next cycle.
- RD_WAIT: on `mem_resp_valid`, write `mem_rdata` into line slot k.
  - If 4 beats received: RESOLVE.
  - Otherwise advance k and return to RD_REQ.
  - At most one read outstanding.
  - `mem_resp_valid` outside RD_WAIT is ignored.
- RESOLVE: `repair_resolved` = 1 for exactly one cycle; `fill_data` and `fill_addr` are valid. `fill_data` and `fill_addr` hold their values until the next RESOLVE. Next state: HOLD.
- HOLD: one cycle. The controller's request is still high because the controller deasserts it registered, so the request is ignored here. Next state: IDLE, `busy` = 0.
- Back-to-back misses:
  - A request high in IDLE right after HOLD is a new miss.
  - Minimum spacing is resolve-to-accept of 2 cycles.
- Minimum latency, clean miss with `ready` = 1 and response the cycle after the handshake: accept + 4×(REQ+WAIT) + RESOLVE = 10 cycles.
- Captured request fields are immune to input changes after acceptance.
- Beat counter is 2 bits and wraps mod 4; completion is tracked by a separate received-beat count.

Optional Feature:
- Macro: REFILL_CWF_EN (critical-word-first).
- Defined: the read sequence starts at word index `missed_addr[3:2]` and wraps ascending, e.g. start 2 gives 2,3,0,1. Each beat lands in its true slot.
- Undefined: reads always run 0,1,2,3.
- Write-back order is ascending in both cases. `fill_data` layout is identical in both cases.

Test Plan:
- Clean miss, `missed_addr` = 0x0000_1234, `ready` = 1, rdata = 0xA0,0xA1,0xA2,0xA3 → reads to 0x1230,0x1234,0x1238,0x123C; `fill_data` = {0xA3,0xA2,0xA1,0xA0}; `fill_addr` = 0x1230; `repair_resolved` pulse at cycle 10; `busy` low 2 cycles later.
- Dirty miss, `evict_addr` = 0x8000, `evict_data` = 128'h4444_4444_3333_3333_2222_2222_1111_1111 → four write beats 0x8000..0x800C carrying 0x1111_1111..0x4444_4444, then reads; exactly 8 handshakes.
- `mem_req_ready` low for 3 cycles on beat 1 → `addr`, `wdata` and `valid` stable throughout; final `fill_data` correct.
- `read_miss_repair` held through HOLD, deasserted 1 cycle after resolve → exactly one `repair_resolved` pulse; no second memory request.
- `rst` asserted during RD_WAIT beat 2 → all outputs 0 asynchronously. A new miss to 0x40 after release completes correctly; the stray old response is ignored.
- REFILL_CWF_EN defined, `missed_addr` = 0x1238 → read order 0x1238,0x123C,0x1230,0x1234; `fill_data` is slot-correct.

Source files
------------

// File: rtl/dcache_refill_engine.sv
// -----------------------------------------------------------------------------
// dcache_refill_engine
//
// Memory-side responder for the data cache miss-repair interface. Accepts a
// held miss request, optionally writes the dirty victim line back to memory
// (four ascending 32-bit beats), then fetches the missing 128-bit line one
// beat at a time with at most one read outstanding. The assembled line is
// returned with a one-cycle repair_resolved pulse, followed by a one-cycle
// HOLD that swallows the controller's still-high request.
//
// Optional feature: define REFILL_CWF_EN for critical-word-first reads. The
// read sequence then starts at missed_addr[3:2] and wraps ascending; without
// it reads always run 0,1,2,3. Write-back order and fill_data layout are the
// same in both builds.
//
// Ports:
//   clk, rst            single clock; asynchronous active-low reset
//   read_miss_repair    level miss request, held until repair_resolved
//   missed_addr         byte address of the missing word (sampled on accept)
//   evict_dirty/_addr/_data  victim line info (sampled on accept)
//   repair_resolved     one-cycle pulse, fill outputs valid
//   fill_data/fill_addr refilled line (word 0 in [31:0]) and its base address
//   busy                high from acceptance through HOLD
//   mem_req_valid/_ready/_we/_addr, mem_wdata   beat request channel
//   mem_resp_valid, mem_rdata                   read data return
// -----------------------------------------------------------------------------
module dcache_refill_engine #(
  parameter int LINE_BITS = 128,
  parameter int BUS_BITS  = 32,
  parameter int ADDR_BITS = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 read_miss_repair,
  input  logic [ADDR_BITS-1:0] missed_addr,
  input  logic                 evict_dirty,
  input  logic [ADDR_BITS-1:0] evict_addr,
  input  logic [LINE_BITS-1:0] evict_data,
  output logic                 repair_resolved,
  output logic [LINE_BITS-1:0] fill_data,
  output logic [ADDR_BITS-1:0] fill_addr,
  output logic                 busy,
  output logic                 mem_req_valid,
  input  logic                 mem_req_ready,
  output logic                 mem_req_we,
  output logic [ADDR_BITS-1:0] mem_req_addr,
  output logic [BUS_BITS-1:0]  mem_wdata,
  input  logic                 mem_resp_valid,
  input  logic [BUS_BITS-1:0]  mem_rdata
);

  localparam int BEATS = LINE_BITS / BUS_BITS;
  localparam int KW    = $clog2(BEATS);          // beat index width
  localparam int WOFF  = $clog2(BUS_BITS / 8);   // byte offset inside a beat
  localparam int LOFF  = KW + WOFF;              // byte offset inside a line
  localparam int BW    = ADDR_BITS - LOFF;       // line base width

  localparam logic [KW-1:0] LAST_BEAT = KW'(BEATS - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_WB,
    S_RD_REQ,
    S_RD_WAIT,
    S_RESOLVE,
    S_HOLD
  } state_t;

  typedef logic [BEATS-1:0][BUS_BITS-1:0] line_t;

  state_t               state_q;
  logic [KW-1:0]        k_q;          // current beat slot, wraps mod BEATS
  logic [KW-1:0]        rcv_q;        // read beats already received
  logic [KW-1:0]        start_q;      // first read slot of this miss
  logic [BW-1:0]        miss_base_q;
  logic [BW-1:0]        evict_base_q;
  line_t                evict_q;
  line_t                line_q;
  line_t                line_d;
  logic [LINE_BITS-1:0] fill_data_q;
  logic [ADDR_BITS-1:0] fill_addr_q;
  logic                 busy_q;
  logic                 resolved_q;
  logic                 req_valid_q;
  logic                 req_we_q;
  logic [ADDR_BITS-1:0] req_addr_q;
  logic [BUS_BITS-1:0]  wdata_q;

  logic [KW-1:0] k_inc;
  logic [KW-1:0] start_word;
  logic          unused_bits;

  assign k_inc = k_q + KW'(1);

`ifdef REFILL_CWF_EN
  assign start_word = missed_addr[LOFF-1:WOFF];
`else
  assign start_word = '0;
`endif

  // Sub-line address bits only select a word; the engine always moves lines.
  assign unused_bits = ^{missed_addr[LOFF-1:0], evict_addr[LOFF-1:0]};

  function automatic logic [ADDR_BITS-1:0] beat_addr(input logic [BW-1:0] base,
                                                     input logic [KW-1:0] k);
    return {base, k, {WOFF{1'b0}}};
  endfunction

  // Line buffer with the incoming read beat merged into its true slot, so the
  // last beat can go straight into fill_data in the same edge.
  always_comb begin
    // NOTE: assign a full default before the partial update; otherwise the
    // untouched slots would have to remember their value and infer a latch.
    line_d        = line_q;
    line_d[k_q]   = mem_rdata;
  end

  // NOTE: all state in this block uses non-blocking assignments so every
  // register samples the pre-edge values, regardless of statement order.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= S_IDLE;
      k_q          <= '0;
      rcv_q        <= '0;
      start_q      <= '0;
      miss_base_q  <= '0;
      evict_base_q <= '0;
      evict_q      <= '0;
      // NOTE: the line buffer is a flop bank rather than a RAM macro, so it is
      // cleared with everything else and never leaks a previous line.
      line_q       <= '0;
      fill_data_q  <= '0;
      fill_addr_q  <= '0;
      busy_q       <= 1'b0;
      resolved_q   <= 1'b0;
      req_valid_q  <= 1'b0;
      req_we_q     <= 1'b0;
      req_addr_q   <= '0;
      wdata_q      <= '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (read_miss_repair) begin
            busy_q       <= 1'b1;
            rcv_q        <= '0;
            start_q      <= start_word;
            miss_base_q  <= missed_addr[ADDR_BITS-1:LOFF];
            evict_base_q <= evict_addr[ADDR_BITS-1:LOFF];
            evict_q      <= evict_data;
            req_valid_q  <= 1'b1;
            if (evict_dirty) begin
              state_q    <= S_WB;
              k_q        <= '0;
              req_we_q   <= 1'b1;
              req_addr_q <= beat_addr(evict_addr[ADDR_BITS-1:LOFF], '0);
              wdata_q    <= evict_data[BUS_BITS-1:0];
            end else begin
              state_q    <= S_RD_REQ;
              k_q        <= start_word;
              req_we_q   <= 1'b0;
              req_addr_q <= beat_addr(missed_addr[ADDR_BITS-1:LOFF], start_word);
              wdata_q    <= '0;
            end
          end
        end

        // valid stays high throughout; a beat only advances on ready.
        S_WB: begin
          if (mem_req_ready) begin
            if (k_q == LAST_BEAT) begin
              state_q    <= S_RD_REQ;
              k_q        <= start_q;
              req_we_q   <= 1'b0;
              req_addr_q <= beat_addr(miss_base_q, start_q);
              wdata_q    <= '0;
            end else begin
              k_q        <= k_inc;
              req_addr_q <= beat_addr(evict_base_q, k_inc);
              wdata_q    <= evict_q[k_inc];
            end
          end
        end

        S_RD_REQ: begin
          if (mem_req_ready) begin
            state_q     <= S_RD_WAIT;
            req_valid_q <= 1'b0;
          end
        end

        // Completion follows the received count, not k_q, because with
        // critical-word-first the slot index wraps before the line is full.
        S_RD_WAIT: begin
          if (mem_resp_valid) begin
            line_q <= line_d;
            rcv_q  <= rcv_q + KW'(1);
            if (rcv_q == LAST_BEAT) begin
              state_q     <= S_RESOLVE;
              resolved_q  <= 1'b1;
              fill_data_q <= line_d;
              fill_addr_q <= beat_addr(miss_base_q, '0);
            end else begin
              state_q     <= S_RD_REQ;
              k_q         <= k_inc;
              req_valid_q <= 1'b1;
              req_addr_q  <= beat_addr(miss_base_q, k_inc);
            end
          end
        end

        S_RESOLVE: begin
          resolved_q <= 1'b0;
          state_q    <= S_HOLD;
        end

        // The controller drops its request one cycle after the pulse; this
        // state absorbs that stale high level.
        S_HOLD: begin
          busy_q  <= 1'b0;
          state_q <= S_IDLE;
        end

        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign repair_resolved = resolved_q;
  assign fill_data       = fill_data_q;
  assign fill_addr       = fill_addr_q;
  assign busy            = busy_q;
  assign mem_req_valid   = req_valid_q;
  assign mem_req_we      = req_we_q;
  assign mem_req_addr    = req_addr_q;
  assign mem_wdata       = wdata_q;

endmodule
